// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port between the
// pipeline WB stage (priority) and a queue of long-latency unit results.
// Also keeps a per-register busy scoreboard for decode hazard stalls and
// raises a one-cycle WB hold when queued results have waited too long.
module rf_write_arbiter #(
   parameter int WORD_LEN   = 32,
   parameter int ADDR_LEN   = 5,
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wb_en,
   input  logic [ADDR_LEN-1:0] wb_addr,
   input  logic [WORD_LEN-1:0] wb_data,
   input  logic                lu_valid,
   output logic                lu_ready,
   input  logic [ADDR_LEN-1:0] lu_addr,
   input  logic [WORD_LEN-1:0] lu_data,
   input  logic                iss_valid,
   input  logic [ADDR_LEN-1:0] iss_dst,
   output logic                iss_stall,
   input  logic [ADDR_LEN-1:0] rd_a1,
   input  logic [ADDR_LEN-1:0] rd_a2,
   output logic                raw_stall,
   output logic                wb_hold,
   output logic                rf_we,
   output logic [ADDR_LEN-1:0] rf_waddr,
   output logic [WORD_LEN-1:0] rf_wdata,
   output logic                waw_err
);

   localparam int NREG  = 2 ** ADDR_LEN;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   // LU result queue storage; head is read directly because it feeds the
   // write port in the same cycle it is selected.
   logic [ADDR_LEN-1:0] addr_mem [FIFO_DEPTH];
   logic [WORD_LEN-1:0] data_mem [FIFO_DEPTH];

   logic [PTR_W-1:0]    rd_ptr_reg, wr_ptr_reg;
   logic [PTR_W:0]      occ_reg;
   logic [NREG-1:0]     busy_reg, busy_next;
   logic [CNT_W-1:0]    starve_reg;
   logic                wb_hold_reg, waw_err_reg;

   logic                fifo_empty, fifo_full;
   logic                wb_grant, pop, push, iss_grant;
   logic [ADDR_LEN-1:0] head_addr;
   logic [WORD_LEN-1:0] head_data;

   assign fifo_empty = (occ_reg == '0);
   assign fifo_full  = (occ_reg == (PTR_W+1)'(FIFO_DEPTH));
   assign head_addr  = addr_mem[rd_ptr_reg];
   assign head_data  = data_mem[rd_ptr_reg];

   // WB to r0 is a no-op, so it never claims the port.
   assign wb_grant  = wb_en & (wb_addr != '0);
   assign pop       = ~wb_grant & ~fifo_empty;
   // Results for r0 are accepted on the handshake but never stored.
   assign push      = lu_valid & ~fifo_full & (lu_addr != '0);
   assign lu_ready  = ~fifo_full;

   assign iss_stall = busy_reg[iss_dst] & (iss_dst != '0);
   assign iss_grant = iss_valid & ~iss_stall & (iss_dst != '0);
   assign raw_stall = busy_reg[rd_a1] | busy_reg[rd_a2];

   assign wb_hold   = wb_hold_reg;
   assign waw_err   = waw_err_reg;

   // Write-port mux: WB first, otherwise drain the queue head.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (wb_grant) begin
         rf_we    = 1'b1;
         rf_waddr = wb_addr;
         rf_wdata = wb_data;
      end else if (pop) begin
         rf_we    = 1'b1;
         rf_waddr = head_addr;
         rf_wdata = head_data;
      end
   end

   // Per-register scoreboard next state; r0 is hardwired not busy.
   // Set and clear never target the same register in one cycle because an
   // issue to a busy register is refused.
   assign busy_next[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
         assign busy_next[gi] =
            (iss_grant && (iss_dst == ADDR_LEN'(gi))) ? 1'b1 :
            (pop && (head_addr == ADDR_LEN'(gi)))     ? 1'b0 :
                                                        busy_reg[gi];
      end
   endgenerate

   // Queue payload write; contents need no reset since occupancy guards them.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_reg] <= lu_addr;
         data_mem[wr_ptr_reg] <= lu_data;
      end
   end

   // Queue pointers and occupancy; simultaneous push and pop keep occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   occ_reg <= occ_reg + 1'b1;
            2'b01:   occ_reg <= occ_reg - 1'b1;
            default: occ_reg <= occ_reg;
         endcase
      end
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (rst) busy_reg <= '0;
      else     busy_reg <= busy_next;
   end

   // Starvation counter: counts denied cycles while results wait; on the
   // cycle that reaches the limit it clears and requests a one-cycle hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_reg  <= '0;
         wb_hold_reg <= 1'b0;
      end else if (fifo_empty || pop) begin
         starve_reg  <= '0;
         wb_hold_reg <= 1'b0;
      end else if (starve_reg == CNT_W'(STARVE_MAX - 1)) begin
         starve_reg  <= '0;
         wb_hold_reg <= 1'b1;
      end else begin
         starve_reg  <= starve_reg + 1'b1;
         wb_hold_reg <= 1'b0;
      end
   end

   // WAW flag: WB wrote a register that still has an LU result pending.
   always_ff @(posedge clk) begin
      if (rst) waw_err_reg <= 1'b0;
      else     waw_err_reg <= wb_grant & busy_reg[wb_addr];
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter.
module tb_rf_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_addr;
   logic [31:0] lu_data;
   logic        iss_valid;
   logic [4:0]  iss_dst;
   logic        iss_stall;
   logic [4:0]  rd_a1;
   logic [4:0]  rd_a2;
   logic        raw_stall;
   logic        wb_hold;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        waw_err;

   int n_vec = 0;
   int n_err = 0;

   rf_write_arbiter #(.WORD_LEN(32), .ADDR_LEN(5), .FIFO_DEPTH(4), .STARVE_MAX(3)) dut (
      .clk(clk), .rst(rst),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
      .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_stall(iss_stall),
      .rd_a1(rd_a1), .rd_a2(rd_a2), .raw_stall(raw_stall),
      .wb_hold(wb_hold), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .waw_err(waw_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance past the next rising edge; inputs are then changed and
   // outputs sampled well away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      wb_en = 0; wb_addr = 0; wb_data = 0;
      lu_valid = 0; lu_addr = 0; lu_data = 0;
      iss_valid = 0; iss_dst = 0; rd_a1 = 0; rd_a2 = 0;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      wb_en = 1; wb_addr = a; wb_data = d;
   endtask

   task automatic lu(input logic [4:0] a, input logic [31:0] d);
      lu_valid = 1; lu_addr = a; lu_data = d;
   endtask

   task automatic chk_port(input string tag, input logic we, input logic [4:0] a,
                           input logic [31:0] d);
      chk({tag, ".we"}, 32'(rf_we), 32'(we));
      if (we) begin
         chk({tag, ".addr"}, 32'(rf_waddr), 32'(a));
         chk({tag, ".data"}, rf_wdata, d);
      end
   endtask

   initial begin
      idle_in();
      rst = 1;
      tick();
      tick();
      rst = 0;
      #1;

      // 1: reset state, idle
      chk("rst.we", 32'(rf_we), 0);
      chk("rst.ready", 32'(lu_ready), 1);
      chk("rst.hold", 32'(wb_hold), 0);
      chk("rst.waw", 32'(waw_err), 0);
      for (int a = 0; a < 32; a++) begin
         rd_a1 = 5'(a); rd_a2 = 5'(31 - a);
         #1;
         chk($sformatf("rst.raw%0d", a), 32'(raw_stall), 0);
      end
      rd_a1 = 0; rd_a2 = 0;

      // 2: issue r5, LU returns r5 later, written in an idle WB cycle
      iss_valid = 1; iss_dst = 5;
      #1;
      chk("iss5.stall", 32'(iss_stall), 0);
      tick();                                   // c1
      iss_valid = 0; rd_a1 = 5;
      #1;
      chk("c1.raw5", 32'(raw_stall), 1);
      chk("c1.issst5", 32'(iss_stall), 1);
      rd_a1 = 4;
      #1;
      chk("c1.raw4", 32'(raw_stall), 0);
      tick();                                   // c2
      tick();                                   // c3
      lu(5, 32'hDEAD); rd_a1 = 5;
      #1;
      chk("c3.ready", 32'(lu_ready), 1);
      chk_port("c3.bypass", 0, 0, 0);
      tick();                                   // c4
      lu_valid = 0;
      #1;
      chk_port("c4.drain", 1, 5, 32'hDEAD);
      chk("c4.raw5", 32'(raw_stall), 1);
      tick();                                   // c5
      #1;
      chk_port("c5.idle", 0, 0, 0);
      chk("c5.raw5", 32'(raw_stall), 0);
      idle_in();

      // 3: continuous WB fills the FIFO, starvation hold, drain
      for (int k = 0; k < 4; k++) begin
         wb(5'(k + 1), 32'h100 + k);
         lu(5'(10 + k), 32'hA0 + k);
         #1;
         chk_port($sformatf("s3.wb%0d", k), 1, 5'(k + 1), 32'h100 + k);
         chk($sformatf("s3.hold%0d", k), 32'(wb_hold), 0);
         chk($sformatf("s3.rdy%0d", k), 32'(lu_ready), 1);
         tick();
      end
      idle_in();                                // cycle 4: drop WB on hold
      #1;
      chk("s3.full", 32'(lu_ready), 0);
      chk("s3.hold", 32'(wb_hold), 1);
      chk_port("s3.drain10", 1, 10, 32'hA0);
      tick();                                   // cycle 5
      #1;
      chk("s3.hold_off", 32'(wb_hold), 0);
      chk("s3.notfull", 32'(lu_ready), 1);
      for (int k = 5; k < 8; k++) begin
         wb(5'(k), 32'h100 + k);
         #1;
         chk($sformatf("s3.hold%0d", k), 32'(wb_hold), 0);
         tick();
      end
      wb(8, 32'h108);                           // cycle 8: hold but WB kept
      #1;
      chk("s3.hold2", 32'(wb_hold), 1);
      chk_port("s3.wbwins", 1, 8, 32'h108);
      tick();                                   // cycle 9
      idle_in();
      #1;
      chk("s3.restart", 32'(wb_hold), 0);
      for (int k = 1; k < 4; k++) begin
         chk_port($sformatf("s3.drain%0d", 10 + k), 1, 5'(10 + k), 32'hA0 + k);
         tick();
      end
      chk_port("s3.empty", 0, 0, 0);

      // 4: WB and FIFO head contend; pop plus push keeps occupancy
      lu(3, 32'h22);
      tick();
      wb(2, 32'h11); lu(4, 32'h44);
      #1;
      chk_port("s4.wb2", 1, 2, 32'h11);
      tick();
      wb_en = 0; lu(6, 32'h66);
      #1;
      chk_port("s4.head3", 1, 3, 32'h22);
      tick();
      idle_in();
      #1;
      chk_port("s4.head4", 1, 4, 32'h44);
      tick();
      #1;
      chk_port("s4.head6", 1, 6, 32'h66);
      tick();
      #1;
      chk_port("s4.empty", 0, 0, 0);

      // 5: WAW on busy r7, refused reissue, LU result to r0 dropped
      iss_valid = 1; iss_dst = 7;
      tick();
      wb(7, 32'h77);
      #1;
      chk("s5.issst7", 32'(iss_stall), 1);
      chk_port("s5.wb7", 1, 7, 32'h77);
      chk("s5.waw_pre", 32'(waw_err), 0);
      tick();
      idle_in(); rd_a2 = 7;
      lu(0, 32'hBAD);
      #1;
      chk("s5.waw", 32'(waw_err), 1);
      chk("s5.raw7", 32'(raw_stall), 1);
      chk("s5.r0ready", 32'(lu_ready), 1);
      tick();
      lu_valid = 0;
      #1;
      chk("s5.waw_off", 32'(waw_err), 0);
      chk_port("s5.r0drop", 0, 0, 0);

      // 6: reset with three queued entries and r7 busy
      iss_valid = 1; iss_dst = 9;
      for (int k = 0; k < 3; k++) begin
         wb(1, 32'h200 + k);
         lu(5'(10 + k), 32'hC0 + k);
         tick();
         iss_valid = 0;
      end
      idle_in();
      rd_a1 = 9; rd_a2 = 7;
      #1;
      chk("s6.raw_pre", 32'(raw_stall), 1);
      chk_port("s6.queued", 1, 10, 32'hC0);
      rst = 1;
      tick();
      rst = 0;
      #1;
      chk_port("s6.flushed", 0, 0, 0);
      chk("s6.raw", 32'(raw_stall), 0);
      chk("s6.ready", 32'(lu_ready), 1);
      chk("s6.hold", 32'(wb_hold), 0);
      tick();
      #1;
      chk_port("s6.still", 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
